// File: rtl/voice_allocator.sv
`timescale 1ns/1ps
// Polyphony voice allocator. Scans one key per clock, turns key level edges into
// note-on/off events and assigns sounding keys to voice slots, stealing the oldest voice when full.
module voice_allocator #(
    parameter int N_KEYS   = 32,
    parameter int N_VOICES = 4,
    parameter int KEY_W    = 5,
    parameter int AGE_W    = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_enable,
    input  logic [N_KEYS-1:0]         i_keys,
    output logic [N_KEYS-1:0]         o_gate,
    output logic [N_VOICES-1:0]       o_voice_active,
    output logic [N_VOICES*KEY_W-1:0] o_voice_key,
    output logic [N_VOICES-1:0]       o_retrig,
    output logic                      o_steal,
    output logic                      o_scan_wrap
);

    localparam int               VIDX_W   = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};
    localparam logic [KEY_W-1:0] LAST_KEY = KEY_W'(N_KEYS - 1);

    logic [KEY_W-1:0]          r_scan_idx;
    logic [N_KEYS-1:0]         r_prev_keys;
    logic [AGE_W-1:0]          r_age [N_VOICES];
    logic [N_VOICES-1:0]       r_active;
    logic [N_VOICES*KEY_W-1:0] r_key;
    logic [N_KEYS-1:0]         r_gate;
    logic [N_VOICES-1:0]       r_retrig;
    logic                      r_steal;
    logic                      r_scan_wrap;

    logic                      w_cur;
    logic                      w_prev;
    logic                      w_note_on;
    logic                      w_note_off;
    logic [N_VOICES-1:0]       w_hit;
    logic                      w_hit_any;
    logic [VIDX_W-1:0]         w_hit_idx;
    logic                      w_free_any;
    logic [VIDX_W-1:0]         w_free_idx;
    logic [VIDX_W-1:0]         w_old_idx;
    logic [AGE_W-1:0]          w_old_age;
    logic [VIDX_W-1:0]         w_sel_idx;
    logic [N_VOICES-1:0]       w_nxt_active;
    logic [N_VOICES*KEY_W-1:0] w_nxt_key;
    logic [AGE_W-1:0]          w_nxt_age [N_VOICES];
    logic [N_VOICES-1:0]       w_nxt_retrig;
    logic                      w_nxt_steal;
    logic [N_KEYS-1:0]         w_nxt_gate;
    logic [KEY_W-1:0]          w_nxt_scan_idx;
    logic                      w_nxt_wrap;

    assign w_cur      = i_keys[r_scan_idx];
    assign w_prev     = r_prev_keys[r_scan_idx];
    assign w_note_on  = i_enable & w_cur & ~w_prev;
    assign w_note_off = i_enable & ~w_cur & w_prev;

    assign w_nxt_scan_idx = (r_scan_idx == LAST_KEY) ? {KEY_W{1'b0}} : (r_scan_idx + 1'b1);
    assign w_nxt_wrap     = i_enable & (r_scan_idx == LAST_KEY);

    // Slot lookup: which active slot holds the scanned key, and the lowest free slot.
    always_comb begin
        w_hit      = {N_VOICES{1'b0}};
        w_hit_idx  = {VIDX_W{1'b0}};
        w_free_idx = {VIDX_W{1'b0}};
        for (int v = N_VOICES - 1; v >= 0; v--) begin
            w_hit[v]   = r_active[v] && (r_key[v*KEY_W +: KEY_W] == r_scan_idx);
            w_hit_idx  = w_hit[v]     ? VIDX_W'(v) : w_hit_idx;
            w_free_idx = !r_active[v] ? VIDX_W'(v) : w_free_idx;
        end
    end

    assign w_hit_any  = |w_hit;
    assign w_free_any = ~&r_active;

    // Oldest slot; strict comparison keeps the lowest index on ties.
    always_comb begin
        w_old_idx = {VIDX_W{1'b0}};
        w_old_age = r_age[0];
        for (int v = 1; v < N_VOICES; v++) begin
            w_old_idx = (r_age[v] > w_old_age) ? VIDX_W'(v) : w_old_idx;
            w_old_age = (r_age[v] > w_old_age) ? r_age[v]   : w_old_age;
        end
    end

    assign w_sel_idx = w_free_any ? w_free_idx : w_old_idx;

    // Slot state update for the event found at the current scan position.
    always_comb begin
        w_nxt_active = r_active;
        w_nxt_key    = r_key;
        w_nxt_age    = r_age;
        w_nxt_retrig = {N_VOICES{1'b0}};
        w_nxt_steal  = 1'b0;
        if (w_note_on && w_hit_any) begin
            w_nxt_retrig[w_hit_idx] = 1'b1;
            w_nxt_age[w_hit_idx]    = {AGE_W{1'b0}};
        end else if (w_note_on) begin
            w_nxt_steal = ~w_free_any;
            for (int v = 0; v < N_VOICES; v++) begin
                if (VIDX_W'(v) == w_sel_idx) begin
                    w_nxt_active[v]             = 1'b1;
                    w_nxt_key[v*KEY_W +: KEY_W] = r_scan_idx;
                    w_nxt_age[v]                = {AGE_W{1'b0}};
                    w_nxt_retrig[v]             = 1'b1;
                end else if (r_active[v] && (r_age[v] != AGE_MAX)) begin
                    w_nxt_age[v] = r_age[v] + 1'b1;
                end else begin
                    w_nxt_age[v] = r_age[v];
                end
            end
        end else if (w_note_off) begin
            for (int v = 0; v < N_VOICES; v++) begin
                if (w_hit[v]) begin
                    w_nxt_active[v]             = 1'b0;
                    w_nxt_key[v*KEY_W +: KEY_W] = {KEY_W{1'b0}};
                    w_nxt_age[v]                = {AGE_W{1'b0}};
                end else begin
                    w_nxt_active[v] = r_active[v];
                end
            end
        end else begin
            w_nxt_steal = 1'b0;
        end
    end

    // Gate mask derived from the slot state that will be registered alongside it.
    always_comb begin
        w_nxt_gate = {N_KEYS{1'b0}};
        for (int v = 0; v < N_VOICES; v++) begin
            w_nxt_gate[w_nxt_key[v*KEY_W +: KEY_W]] =
                w_nxt_gate[w_nxt_key[v*KEY_W +: KEY_W]] | w_nxt_active[v];
        end
    end

    // Scanner, slot state and registered outputs; a frozen scanner holds state and drops pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scan_idx  <= {KEY_W{1'b0}};
            r_prev_keys <= {N_KEYS{1'b0}};
            r_age       <= '{default: {AGE_W{1'b0}}};
            r_active    <= {N_VOICES{1'b0}};
            r_key       <= {(N_VOICES*KEY_W){1'b0}};
            r_gate      <= {N_KEYS{1'b0}};
            r_retrig    <= {N_VOICES{1'b0}};
            r_steal     <= 1'b0;
            r_scan_wrap <= 1'b0;
        end else if (i_enable) begin
            r_scan_idx              <= w_nxt_scan_idx;
            r_prev_keys[r_scan_idx] <= w_cur;
            r_age                   <= w_nxt_age;
            r_active                <= w_nxt_active;
            r_key                   <= w_nxt_key;
            r_gate                  <= w_nxt_gate;
            r_retrig                <= w_nxt_retrig;
            r_steal                 <= w_nxt_steal;
            r_scan_wrap             <= w_nxt_wrap;
        end else begin
            r_retrig    <= {N_VOICES{1'b0}};
            r_steal     <= 1'b0;
            r_scan_wrap <= 1'b0;
        end
    end

    assign o_gate         = r_gate;
    assign o_voice_active = r_active;
    assign o_voice_key    = r_key;
    assign o_retrig       = r_retrig;
    assign o_steal        = r_steal;
    assign o_scan_wrap    = r_scan_wrap;

endmodule
